// File: rtl/rgbw_pwm_spi_lamp.sv
// SPI (mode 1) controlled RGBW PWM lamp driver.
// Receives sync-prefixed colour frames, scales by intensity, drives four PWM pins.
module rgbw_pwm_spi_lamp #(
    parameter int unsigned PWM_BITS  = 8,
    parameter logic [7:0]  SYNC_BYTE = 8'h55,
    parameter int unsigned FRAME_LEN = 8
) (
    input  logic clk12,
    input  logic reset,
    input  logic sck0,
    input  logic mosi,
    input  logic cs,
    output logic red_pin,
    output logic green_pin,
    output logic blue_pin,
    output logic white_pin
);

    localparam int unsigned IdxW = $clog2(FRAME_LEN);

    typedef enum logic [0:0] {StWaitSync, StReceive} state_e;

    logic [1:0] sck_sync_q, mosi_sync_q, cs_sync_q;
    logic       sck_prev_q;
    logic       sck_fall, mosi_s, cs_s;

    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_vld_q, byte_vld_d;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            commit_q, commit_d;
    logic [7:0]      intensity_q, intensity_d;
    logic [7:0]      mode_q, mode_d;
    logic [7:0]      col_q [4];
    logic [7:0]      col_d [4];

    logic [PWM_BITS-1:0] pend_q [4];
    logic [PWM_BITS-1:0] pend_d [4];
    logic [PWM_BITS-1:0] act_q [4];
    logic [PWM_BITS-1:0] act_d [4];
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [3:0]          pin_q, pin_d;

    // duty = colour * (intensity + 1) >> 8; the product always fits in 16 bits
    function automatic logic [PWM_BITS-1:0] scale(input logic [7:0] c, input logic [7:0] i);
        logic [15:0] p;
        p = 16'(c) * (16'(i) + 16'd1);
        return PWM_BITS'(p[15:8]);
    endfunction

    assign mosi_s   = mosi_sync_q[1];
    assign cs_s     = cs_sync_q[1];
    assign sck_fall = sck_prev_q & ~sck_sync_q[1];

    always_comb begin
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_vld_d = 1'b0;
        if (cs_s) begin
            bit_cnt_d = 3'd0;
        end else if (sck_fall) begin
            shift_d    = {shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            byte_vld_d = (bit_cnt_q == 3'd7);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        commit_d    = 1'b0;
        intensity_d = intensity_q;
        mode_d      = mode_q;
        col_d       = col_q;
        if (byte_vld_q) begin
            unique case (state_q)
                StWaitSync: begin
                    if (shift_q == SYNC_BYTE) begin
                        idx_d   = IdxW'(1);
                        state_d = StReceive;
                    end
                end
                StReceive: begin
                    case (idx_q)
                        IdxW'(1): intensity_d = shift_q;
                        IdxW'(2): mode_d      = shift_q;
                        IdxW'(3): col_d[0]    = shift_q;
                        IdxW'(4): col_d[1]    = shift_q;
                        IdxW'(5): col_d[2]    = shift_q;
                        IdxW'(6): col_d[3]    = shift_q;
                        default: ;
                    endcase
                    if (idx_q == IdxW'(FRAME_LEN - 1)) begin
                        commit_d = 1'b1;
                        idx_d    = '0;
                        state_d  = StWaitSync;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
                default: state_d = StWaitSync;
            endcase
        end
    end

    // Pending duties only move to active on the wrap, so periods never tear
    always_comb begin
        cnt_d = cnt_q + PWM_BITS'(1);
        for (int c = 0; c < 4; c++) begin
            pend_d[c] = pend_q[c];
            if (commit_q) begin
                pend_d[c] = (mode_q[7] && c < 3) ? '0 : scale(col_q[c], intensity_q);
            end
            act_d[c] = (cnt_q == '1) ? pend_q[c] : act_q[c];
            pin_d[c] = (cnt_q < act_q[c]);
        end
    end

    always_ff @(posedge clk12 or negedge reset) begin
        if (!reset) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sck_prev_q  <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_vld_q  <= 1'b0;
            state_q     <= StWaitSync;
            idx_q       <= '0;
            commit_q    <= 1'b0;
            intensity_q <= '0;
            mode_q      <= '0;
            cnt_q       <= '0;
            pin_q       <= '0;
            for (int c = 0; c < 4; c++) begin
                col_q[c]  <= '0;
                pend_q[c] <= '0;
                act_q[c]  <= '0;
            end
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck0};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            cs_sync_q   <= {cs_sync_q[0], cs};
            sck_prev_q  <= sck_sync_q[1];
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_vld_q  <= byte_vld_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            commit_q    <= commit_d;
            intensity_q <= intensity_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            pin_q       <= pin_d;
            for (int c = 0; c < 4; c++) begin
                col_q[c]  <= col_d[c];
                pend_q[c] <= pend_d[c];
                act_q[c]  <= act_d[c];
            end
        end
    end

    assign red_pin   = pin_q[0];
    assign green_pin = pin_q[1];
    assign blue_pin  = pin_q[2];
    assign white_pin = pin_q[3];

endmodule

// File: tb/tb_rgbw_pwm_spi_lamp.sv
// Directed bench for rgbw_pwm_spi_lamp: SPI frames in, PWM high-time counted per 256-cycle window.
module tb_rgbw_pwm_spi_lamp;

    logic clk12 = 1'b0;
    logic reset = 1'b0;
    logic sck0  = 1'b0;
    logic mosi  = 1'b0;
    logic cs    = 1'b1;
    logic red_pin, green_pin, blue_pin, white_pin;

    rgbw_pwm_spi_lamp dut (
        .clk12    (clk12),
        .reset    (reset),
        .sck0     (sck0),
        .mosi     (mosi),
        .cs       (cs),
        .red_pin  (red_pin),
        .green_pin(green_pin),
        .blue_pin (blue_pin),
        .white_pin(white_pin)
    );

    always #5 clk12 = ~clk12;

    typedef struct {
        string tag;
        int    r, g, b, w;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int scale(input int c, input int i);
        return (c * (i + 1)) / 256;
    endfunction

    // Mode 1: idle low, data launched on rising edge, sampled on falling edge
    task automatic send_bits(input logic [7:0] v, input int nbits);
        cs = 1'b0;
        #100;
        for (int i = 7; i > 7 - nbits; i--) begin
            sck0 = 1'b1;
            mosi = v[i];
            #80;
            sck0 = 1'b0;
            #80;
        end
        #100;
        cs = 1'b1;
        #200;
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_bits(v, 8);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] f [8]);
        for (int i = 0; i < 8; i++) send_byte(f[i]);
        cur.tag = tag;
        cur.r   = f[2][7] ? 0 : scale(int'(f[3]), int'(f[1]));
        cur.g   = f[2][7] ? 0 : scale(int'(f[4]), int'(f[1]));
        cur.b   = f[2][7] ? 0 : scale(int'(f[5]), int'(f[1]));
        cur.w   = scale(int'(f[6]), int'(f[1]));
        sb.push_back(cur);
    endtask

    task automatic measure_and_check();
        int   r, g, b, w;
        exp_t e;
        r = 0; g = 0; b = 0; w = 0;
        repeat (300) @(posedge clk12);
        repeat (256) begin
            @(negedge clk12);
            r += int'(red_pin);
            g += int'(green_pin);
            b += int'(blue_pin);
            w += int'(white_pin);
        end
        check("sb_nonempty", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({e.tag, "_red"}, r, e.r);
            check({e.tag, "_green"}, g, e.g);
            check({e.tag, "_blue"}, b, e.b);
            check({e.tag, "_white"}, w, e.w);
        end
    endtask

    task automatic pins_zero(input string tag);
        check({tag, "_pins"}, int'({red_pin, green_pin, blue_pin, white_pin}), 0);
    endtask

    task automatic push_cur(input string tag);
        cur.tag = tag;
        sb.push_back(cur);
    endtask

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] fr [8];
        cur = '{tag: "init", r: 0, g: 0, b: 0, w: 0};

        repeat (10) @(posedge clk12);
        @(negedge clk12);
        pins_zero("in_reset");
        reset = 1'b1;
        repeat (3) @(negedge clk12);
        pins_zero("after_reset");
        push_cur("reset");
        measure_and_check();

        fr = '{8'h55, 8'hFF, 8'h24, 8'h00, 8'hFF, 8'h00, 8'hAA, 8'hA4};
        send_frame("f1", fr);
        measure_and_check();

        fr = '{8'h55, 8'hFF, 8'h25, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hA4};
        send_frame("f2", fr);
        measure_and_check();

        fr = '{8'h55, 8'hFF, 8'hA0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h21};
        send_frame("mode7", fr);
        measure_and_check();

        fr = '{8'h55, 8'h80, 8'h24, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hA4};
        send_frame("half", fr);
        measure_and_check();

        send_byte(8'h54);
        send_byte(8'hFF);
        send_byte(8'h24);
        push_cur("misalign");
        measure_and_check();

        fr = '{8'h55, 8'hFF, 8'h24, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hA4};
        send_frame("realign", fr);
        measure_and_check();

        send_byte(8'h55);
        send_byte(8'hFF);
        send_byte(8'h24);
        send_byte(8'hFF);
        @(negedge clk12);
        reset = 1'b0;
        repeat (10) @(negedge clk12);
        pins_zero("mid_reset");
        reset = 1'b1;
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hA4);
        cur = '{tag: "", r: 0, g: 0, b: 0, w: 0};
        push_cur("post_reset");
        measure_and_check();

        fr = '{8'h55, 8'h40, 8'h24, 8'h00, 8'h00, 8'hC8, 8'h00, 8'hA4};
        send_frame("recover", fr);
        measure_and_check();

        send_bits(8'hA0, 4);
        fr = '{8'h55, 8'hFF, 8'h24, 8'h00, 8'h00, 8'h00, 8'h7F, 8'hA4};
        send_frame("partial", fr);
        measure_and_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgbw_pwm_spi_lamp.md
Name: rgbw_pwm_spi_lamp

Overview:
- SPI-controlled four-channel (red, green, blue, white) LED PWM driver.
- Receives 8-byte colour frames from an external SPI master (mode 1, CPOL=0, CPHA=1, MSB first).
- Scales each colour by a global intensity and drives four PWM pins in the clk12 domain.
- Sits between the board SPI header and the LED driver transistors.

Parameters:
- PWM_BITS, 8, PWM counter and duty width.
- SYNC_BYTE, 8'h55, required first byte of every frame.
- FRAME_LEN, 8, bytes per frame including the sync byte.

Ports:
- clk12  input  1  system clock, about 12 MHz; all logic runs on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- sck0  input  1  SPI clock from master, asynchronous to clk12.
- mosi  input  1  SPI data from master.
- cs  input  1  SPI chip select, active-low.
- red_pin  output  1  red PWM output, active-high.
- green_pin  output  1  green PWM output.
- blue_pin  output  1  blue PWM output.
- white_pin  output  1  white PWM output.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - Shift register, bit counter, byte index, frame registers, shadow duties and PWM counter all clear to 0.
  - Receiver returns to WAIT_SYNC.
- Input synchronisers:
  - sck0, mosi and cs each pass through a 2-flop synchroniser into clk12.
  - Requirement: clk12 is at least 8x the sck0 frequency.
- Bit capture (mode 1):
  - On a synchronised falling edge of sck while cs=0, shift mosi into bit 0 (MSB first) and increment a 3-bit counter.
  - When the 8th bit arrives, a byte-valid strobe pulses for 1 clk12.
- Chip select:
  - cs=1 clears the bit counter and discards partial bits.
  - cs=1 does not reset the byte index; each byte may be framed by its own cs pulse.
- Frame state machine:
  - WAIT_SYNC: a byte equal to SYNC_BYTE sets index=1 and moves to RECEIVE. Any other byte is dropped and the state is unchanged.
  - RECEIVE: byte k is stored in the slot for index k, then index increments.
    - idx1 = intensity
    - idx2 = mode
    - idx3 = red
    - idx4 = green
    - idx5 = blue
    - idx6 = white
    - idx7 = tail (received, value ignored)
  - On the idx7 byte, commit 1 clk12 later, then return to WAIT_SYNC.
  - No 0x55 resync inside a frame; payload bytes may equal 0x55.
- Commit (one cycle):
  - duty_c = (colour_c * (intensity + 1)) >> 8, an 8-bit result; 16-bit product, no overflow.
  - If mode[7]=1, duties for red, green and blue are forced to 0 and white is computed normally.
  - mode[6:0] are reserved and ignored.
  - Results go to pending registers.
- PWM:
  - Free-running 8-bit counter, +1 every clk12, wraps 255 to 0.
  - Pending duties copy into active duties on the cycle the counter wraps to 0, which keeps periods glitch-free.
  - pin = (counter < active_duty), registered.
  - Duty 0 gives a pin that is constantly 0.
  - Duty 255 gives 255 high cycles out of every 256.
- Latency: outputs reflect a new frame within 258 clk12 cycles of the final byte's 8th sck falling edge, plus synchroniser delay.
- Simultaneous events:
  - Commit on the wrap cycle: the new pending value is applied at the next wrap, not the current one.
  - A byte strobe while reset is asserted is ignored.
- Reset mid-frame: the partial frame is lost, outputs go to 0, and the next frame must start with 0x55.

Test Plan:
- Reset pulse of 10 cycles low, then release → all four pins 0. Each byte sent under its own cs pulse: 55 FF 24 00 FF 00 AA A4 → red=0 and blue=0 constant; green high 255 of 256 cycles; white high 0xAA (170) of 256 cycles.
- Send 55 FF 25 00 FF 00 00 A4 → white constant 0; green duty 255; mode bits 6:0 have no effect.
- Send 55 FF A0 FF 00 00 00 21 → red forced 0 by mode[7]; all pins 0. Then send 55 80 24 FF 00 00 00 A4 → red duty 0x80 (128 of 256).
- Send misaligned bytes 54 FF 24 then a valid frame 55 FF 24 FF 00 00 00 A4 → the first three bytes are ignored; red duty 255 after the valid frame only.
- Assert reset after byte 4 of a frame, then complete the remaining bytes → pins stay 0 and no commit occurs. A subsequent full frame updates correctly.
- Raise cs after 4 sck bits of a byte, then send a full byte 0x55 and a valid remainder → the partial bits are discarded and the frame is received correctly.
